// File: rtl/jt7759_seq.sv
// jt7759_seq: phrase sequencer; reads the phrase table, interprets commands, streams ADPCM nibbles.
// Latency: busyn falls one clk after start; each byte is a cs/ok handshake; nibbles leave one clk after cen_dec.
// Backpressure: waits on ctrl_ok per byte; a cen_dec tick with no nibble buffered is skipped.
module jt7759_seq #(
  parameter int SILENCE_UNIT = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen_dec,
  input  logic        start,
  input  logic [7:0]  phrase,
  output logic        busyn,
  output logic        ctrl_cs,
  output logic        ctrl_busyn,
  output logic [16:0] ctrl_addr,
  input  logic [7:0]  ctrl_din,
  input  logic        ctrl_ok,
  output logic        dec_valid,
  output logic [3:0]  dec_nibble,
  output logic        dec_rst,
  output logic        mute
);

  localparam int SW = $clog2(63 * SILENCE_UNIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH, S_RD_MAX, S_RD_HI, S_RD_LO,
    S_RD_CMD, S_RD_CNT, S_SILENCE, S_PLAY
  } state_t;

  state_t        state_q, state_d, pend_q, pend_d;
  logic [7:0]    phrase_q, phrase_d, hi_q, hi_d;
  logic [16:0]   addr_q, addr_d;
  logic          cs_q, cs_d;
  logic [8:0]    cnt_q, cnt_d;       // nibbles still to emit in this PLAY block
  logic [7:0]    bleft_q, bleft_d;   // bytes still to fetch in this PLAY block
  logic [7:0]    cur_q, cur_d, nxt_q, nxt_d;
  logic          cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic          half_q, half_d;     // 1: high nibble of cur already emitted
  logic [SW-1:0] sil_q, sil_d;
  logic          busyn_q, busyn_d, cbusyn_q, cbusyn_d;
  logic          dvld_q, dvld_d, drst_q, drst_d, mute_q, mute_d;
  logic [3:0]    dnib_q, dnib_d;
  logic          cap, emit, want;

  // Next-state logic: command interpretation, byte handshake and nibble buffering
  always_comb begin
    state_d   = state_q;   pend_d    = pend_q;
    phrase_d  = phrase_q;  hi_d      = hi_q;
    addr_d    = addr_q;    cs_d      = cs_q;
    cnt_d     = cnt_q;     bleft_d   = bleft_q;
    cur_d     = cur_q;     cur_vld_d = cur_vld_q;
    nxt_d     = nxt_q;     nxt_vld_d = nxt_vld_q;
    half_d    = half_q;    sil_d     = sil_q;
    dnib_d    = dnib_q;    dvld_d    = 1'b0;
    cap       = cs_q & ctrl_ok;
    emit      = 1'b0;
    // Prefetch only once the high nibble of the current byte is out, one byte deep
    want      = (state_q inside {S_RD_MAX, S_RD_HI, S_RD_LO, S_RD_CMD, S_RD_CNT}) ||
                (state_q == S_PLAY && bleft_q != 8'd0 && !nxt_vld_q && (!cur_vld_q || half_q));

    if (start) begin
      phrase_d  = phrase;
      addr_d    = '0;
      state_d   = S_FLUSH;
      pend_d    = S_RD_MAX;
      cs_d      = 1'b0;
      cur_vld_d = 1'b0;
      nxt_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_FLUSH: state_d = pend_q;
        S_RD_MAX: if (cap) begin
          if (phrase_q > ctrl_din) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = 17'd5 + {8'd0, phrase_q, 1'b0};
            state_d = S_FLUSH;
            pend_d  = S_RD_HI;
          end
        end
        S_RD_HI: if (cap) begin
          hi_d    = ctrl_din;
          addr_d  = addr_q + 17'd1;
          state_d = S_RD_LO;
        end
        S_RD_LO: if (cap) begin
          addr_d  = {hi_q, ctrl_din, 1'b0};
          state_d = S_FLUSH;
          pend_d  = S_RD_CMD;
        end
        S_RD_CMD: if (cap) begin
          addr_d    = addr_q + 17'd1;
          cur_vld_d = 1'b0;
          nxt_vld_d = 1'b0;
          half_d    = 1'b0;
          case (ctrl_din[7:6])
            2'b00: begin
              if (ctrl_din[5:0] == 6'd0) state_d = S_IDLE;
              else begin
                state_d = S_SILENCE;
                sil_d   = SW'(32'(ctrl_din[5:0]) * SILENCE_UNIT);
              end
            end
            2'b01: begin
              state_d = S_PLAY;
              cnt_d   = 9'd256;
              bleft_d = 8'd128;
            end
            2'b10:   state_d = S_RD_CNT;
            default: state_d = S_IDLE;
          endcase
        end
        S_RD_CNT: if (cap) begin
          addr_d  = addr_q + 17'd1;
          cnt_d   = {1'b0, ctrl_din} + 9'd1;
          bleft_d = 8'(({1'b0, ctrl_din} + 9'd2) >> 1);
          state_d = S_PLAY;
        end
        S_SILENCE: if (cen_dec) begin
          if (sil_q <= SW'(1)) state_d = S_RD_CMD;
          else                 sil_d   = sil_q - SW'(1);
        end
        S_PLAY: begin
          if (cen_dec && cur_vld_q) begin
            emit   = 1'b1;
            dvld_d = 1'b1;
            dnib_d = half_q ? cur_q[3:0] : cur_q[7:4];
            cnt_d  = cnt_q - 9'd1;
            // Odd count: the low nibble of the last byte is dropped here
            if (half_q || cnt_q == 9'd1) cur_vld_d = 1'b0;
            else                         half_d    = 1'b1;
          end
          if (!cur_vld_d && nxt_vld_q) begin
            cur_d     = nxt_q;
            cur_vld_d = 1'b1;
            half_d    = 1'b0;
            nxt_vld_d = 1'b0;
          end
          if (cap) begin
            addr_d  = addr_q + 17'd1;
            bleft_d = bleft_q - 8'd1;
            if (!cur_vld_d) begin
              cur_d     = ctrl_din;
              cur_vld_d = 1'b1;
              half_d    = 1'b0;
            end else begin
              nxt_d     = ctrl_din;
              nxt_vld_d = 1'b1;
            end
          end
          if (emit && cnt_q == 9'd1) state_d = S_RD_CMD;
        end
        default: state_d = S_IDLE;
      endcase
      // A captured byte always drops cs for at least one clk before the next request
      if (cap)              cs_d = 1'b0;
      else if (!cs_q && want) cs_d = 1'b1;
    end

    busyn_d  = (state_d == S_IDLE);
    cbusyn_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    // Decoder state survives between PLAY blocks; only IDLE and SILENCE clear it
    if (state_d == S_IDLE || state_d == S_SILENCE) begin
      drst_d = 1'b1;
      mute_d = 1'b1;
    end else if (state_d == S_PLAY) begin
      drst_d = 1'b0;
      mute_d = 1'b0;
    end else begin
      drst_d = drst_q;
      mute_d = mute_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;  pend_q    <= S_RD_MAX;
      phrase_q  <= '0;      hi_q      <= '0;
      addr_q    <= '0;      cs_q      <= 1'b0;
      cnt_q     <= '0;      bleft_q   <= '0;
      cur_q     <= '0;      cur_vld_q <= 1'b0;
      nxt_q     <= '0;      nxt_vld_q <= 1'b0;
      half_q    <= 1'b0;    sil_q     <= '0;
      busyn_q   <= 1'b1;    cbusyn_q  <= 1'b1;
      dvld_q    <= 1'b0;    dnib_q    <= '0;
      drst_q    <= 1'b1;    mute_q    <= 1'b1;
    end else begin
      state_q   <= state_d;   pend_q    <= pend_d;
      phrase_q  <= phrase_d;  hi_q      <= hi_d;
      addr_q    <= addr_d;    cs_q      <= cs_d;
      cnt_q     <= cnt_d;     bleft_q   <= bleft_d;
      cur_q     <= cur_d;     cur_vld_q <= cur_vld_d;
      nxt_q     <= nxt_d;     nxt_vld_q <= nxt_vld_d;
      half_q    <= half_d;    sil_q     <= sil_d;
      busyn_q   <= busyn_d;   cbusyn_q  <= cbusyn_d;
      dvld_q    <= dvld_d;    dnib_q    <= dnib_d;
      drst_q    <= drst_d;    mute_q    <= mute_d;
    end
  end

  assign busyn      = busyn_q;
  assign ctrl_cs    = cs_q;
  assign ctrl_busyn = cbusyn_q;
  assign ctrl_addr  = addr_q;
  assign dec_valid  = dvld_q;
  assign dec_nibble = dnib_q;
  assign dec_rst    = drst_q;
  assign mute       = mute_q;

endmodule

// File: tb/tb_jt7759_seq.sv
// Bench for jt7759_seq: ROM-backed data block model, phrase-walking reference model,
// table-driven phrase runs, hand-written silence/restart/reset sequences, random phrases.
module tb_jt7759_seq;

  logic        clk = 1'b0, rstn = 1'b0, cen_dec = 1'b0, start = 1'b0;
  logic [7:0]  phrase = '0;
  logic        busyn, ctrl_cs, ctrl_busyn, ctrl_ok = 1'b0;
  logic [16:0] ctrl_addr;
  logic [7:0]  ctrl_din = '0;
  logic        dec_valid, dec_rst, mute;
  logic [3:0]  dec_nibble;

  jt7759_seq #(.SILENCE_UNIT(32)) dut (
    .clk(clk), .rstn(rstn), .cen_dec(cen_dec), .start(start), .phrase(phrase),
    .busyn(busyn), .ctrl_cs(ctrl_cs), .ctrl_busyn(ctrl_busyn), .ctrl_addr(ctrl_addr),
    .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok), .dec_valid(dec_valid), .dec_nibble(dec_nibble),
    .dec_rst(dec_rst), .mute(mute)
  );

  initial forever #5 clk = ~clk;

  logic [7:0]  rom [0:131071];
  int          checks = 0, errors = 0;
  int          rsp_lat = 0, cen_per = 2;
  logic [16:0] resp_addr = '0;
  logic [16:0] got_reads[$], exp_reads[$];
  logic [3:0]  got_nibs[$],  exp_nibs[$];
  int          tick_ctr = 0, t0 = 0, t1 = 0, sil_mute_bad = 0;
  bit          sil_win = 1'b0;

  typedef struct {
    logic [7:0]  ph;
    int          lat;
    int          cper;
    int          exp_nibs;
    int          exp_reads;
    logic [16:0] exp_last;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Data block: answers each request after rsp_lat clks of ctrl_cs
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!ctrl_cs) begin
        ctrl_ok = 1'b0;
        wcnt    = 0;
      end else if (!ctrl_ok) begin
        if (wcnt >= rsp_lat) begin
          ctrl_ok   = 1'b1;
          ctrl_din  = rom[ctrl_addr];
          resp_addr = ctrl_addr;
          got_reads.push_back(ctrl_addr);
        end else wcnt++;
      end
    end
  end

  // Decoder enable: one pulse every cen_per clks
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      cen_dec = (c % cen_per) == 0;
      c++;
    end
  end

  // Output monitor, sampled just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (dec_valid) got_nibs.push_back(dec_nibble);
    if (cen_dec) tick_ctr++;
    if (ctrl_ok && !ctrl_cs) begin
      if (resp_addr == 17'hE0) begin
        t0 = tick_ctr; sil_win = 1'b1;
      end else if (resp_addr == 17'hE1 && sil_win) begin
        t1 = tick_ctr; sil_win = 1'b0;
      end
    end
    if (sil_win && (!mute || dec_valid)) sil_mute_bad++;
  end

  // Reference: walk the phrase by the ROM rules and list reads and nibbles
  task automatic model(input logic [7:0] ph);
    logic [16:0] a;
    logic [7:0]  c, b;
    int          n, nb, guard;
    exp_reads.delete();
    exp_nibs.delete();
    exp_reads.push_back(17'd0);
    if (ph > rom[0]) return;
    a = 17'(5 + 2 * int'(ph));
    exp_reads.push_back(a);
    exp_reads.push_back(a + 17'd1);
    a = {rom[a], rom[a + 17'd1], 1'b0};
    for (guard = 0; guard < 1000; guard++) begin
      c = rom[a];
      exp_reads.push_back(a);
      a = a + 17'd1;
      if (c == 8'h00 || c[7:6] == 2'b11) break;
      if (c[7:6] == 2'b00) continue;
      if (c[7:6] == 2'b01) n = 256;
      else begin
        exp_reads.push_back(a);
        n = int'(rom[a]) + 1;
        a = a + 17'd1;
      end
      nb = (n + 1) / 2;
      for (int k = 0; k < nb; k++) exp_reads.push_back(a + 17'(k));
      for (int i = 0; i < n; i++) begin
        b = rom[a + 17'(i / 2)];
        exp_nibs.push_back((i % 2) ? b[3:0] : b[7:4]);
      end
      a = a + 17'(nb);
    end
  endtask

  task automatic cmp_model(input string nm);
    int mm = 0;
    chk({nm, "_reads_len"}, 32'(got_reads.size()), 32'(exp_reads.size()));
    for (int k = 0; k < exp_reads.size(); k++)
      if (k >= got_reads.size() || got_reads[k] !== exp_reads[k]) mm++;
    chk({nm, "_reads_seq"}, 32'(mm), 32'd0);
    mm = 0;
    chk({nm, "_nibs_len"}, 32'(got_nibs.size()), 32'(exp_nibs.size()));
    for (int k = 0; k < exp_nibs.size(); k++)
      if (k >= got_nibs.size() || got_nibs[k] !== exp_nibs[k]) mm++;
    chk({nm, "_nibs_seq"}, 32'(mm), 32'd0);
  endtask

  task automatic run_phrase(input logic [7:0] ph, input int lat, input int cper);
    int n;
    rsp_lat = lat;
    cen_per = cper;
    got_reads.delete();
    got_nibs.delete();
    @(negedge clk);
    phrase = ph; start = 1'b1;
    @(negedge clk);
    start = 1'b0; phrase = 8'($urandom);
    chk("busyn_fall", 32'(busyn), 32'd0);
    n = 0;
    while (busyn !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("phrase_done_in_budget", 32'(busyn), 32'd1);
    repeat (2) @(negedge clk);
    chk("idle_outputs", 32'({ctrl_busyn, mute, dec_rst, ctrl_cs}), 32'b1110);
  endtask

  task automatic gen_rand();
    logic [16:0] a;
    int          kinds, n;
    a = 17'h100;
    kinds = $urandom_range(2, 4);
    for (int k = 0; k < kinds; k++) begin
      case ($urandom_range(0, 3))
        0: begin rom[a] = 8'($urandom_range(1, 2)); a++; end
        1: begin
          rom[a] = 8'h40 | 8'($urandom_range(0, 63)); a++;
          for (int j = 0; j < 128; j++) begin rom[a] = 8'($urandom); a++; end
        end
        default: begin
          n = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(200, 255);
          rom[a] = 8'h80 | 8'($urandom_range(0, 63)); a++;
          rom[a] = 8'(n); a++;
          for (int j = 0; j < (n + 2) / 2; j++) begin rom[a] = 8'($urandom); a++; end
        end
      endcase
    end
    rom[a] = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'hC0 | 8'($urandom_range(0, 63)));
  endtask

  initial begin
    int          n, mm;
    logic [3:0]  hand_ae [5];
    logic [7:0]  rph;

    tbl[0] = '{ph: 8'd1, lat: 0,  cper: 2, exp_nibs: 256, exp_reads: 133, exp_last: 17'hA1};
    tbl[1] = '{ph: 8'd4, lat: 1,  cper: 3, exp_nibs: 0,   exp_reads: 1,   exp_last: 17'h0};
    tbl[2] = '{ph: 8'd0, lat: 2,  cper: 3, exp_nibs: 5,   exp_reads: 9,   exp_last: 17'hC5};
    tbl[3] = '{ph: 8'd2, lat: 0,  cper: 4, exp_nibs: 0,   exp_reads: 5,   exp_last: 17'hE1};
    tbl[4] = '{ph: 8'd1, lat: 20, cper: 4, exp_nibs: 256, exp_reads: 133, exp_last: 17'hA1};
    hand_ae = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    for (int i = 0; i < 131072; i++) rom[i] = 8'h00;
    rom[0] = 8'd3;
    rom[1] = 8'h37; rom[2] = 8'h37; rom[3] = 8'h35; rom[4] = 8'h39;
    rom[5] = 8'h00; rom[6]  = 8'h60;   // phrase 0 -> 0xC0
    rom[7] = 8'h00; rom[8]  = 8'h10;   // phrase 1 -> 0x20
    rom[9] = 8'h00; rom[10] = 8'h70;   // phrase 2 -> 0xE0
    rom[11] = 8'h00; rom[12] = 8'h80;  // phrase 3 -> 0x100
    rom[17'h20] = 8'h41;
    for (int i = 0; i < 128; i++) rom[17'h21 + i] = 8'h12;
    rom[17'hA1] = 8'h00;
    rom[17'hC0] = 8'h80; rom[17'hC1] = 8'h04; rom[17'hC2] = 8'hAB;
    rom[17'hC3] = 8'hCD; rom[17'hC4] = 8'hEF; rom[17'hC5] = 8'h00;
    rom[17'hE0] = 8'h03; rom[17'hE1] = 8'h00;
    gen_rand();

    repeat (3) @(negedge clk);
    chk("rst_busyn",      32'(busyn),      32'd1);
    chk("rst_ctrl_cs",    32'(ctrl_cs),    32'd0);
    chk("rst_ctrl_busyn", 32'(ctrl_busyn), 32'd1);
    chk("rst_ctrl_addr",  32'(ctrl_addr),  32'd0);
    chk("rst_dec_valid",  32'(dec_valid),  32'd0);
    chk("rst_dec_nibble", 32'(dec_nibble), 32'd0);
    chk("rst_dec_rst",    32'(dec_rst),    32'd1);
    chk("rst_mute",       32'(mute),       32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_phrase(tbl[i].ph, tbl[i].lat, tbl[i].cper);
      model(tbl[i].ph);
      chk($sformatf("tbl%0d_nib_count", i),  32'(got_nibs.size()),  32'(tbl[i].exp_nibs));
      chk($sformatf("tbl%0d_read_count", i), 32'(got_reads.size()), 32'(tbl[i].exp_reads));
      if (got_reads.size() > 0)
        chk($sformatf("tbl%0d_last_read", i), 32'(got_reads[$]), 32'(tbl[i].exp_last));
      cmp_model($sformatf("tbl%0d", i));
      if (tbl[i].ph == 8'd1) begin
        mm = 0;
        for (int k = 0; k < got_nibs.size(); k++)
          if (got_nibs[k] !== ((k % 2) ? 4'h2 : 4'h1)) mm++;
        chk($sformatf("tbl%0d_alt_1_2", i), 32'(mm), 32'd0);
      end
      if (tbl[i].ph == 8'd0) begin
        mm = 0;
        for (int k = 0; k < 5; k++)
          if (k >= got_nibs.size() || got_nibs[k] !== hand_ae[k]) mm++;
        chk("nibs_A_to_E", 32'(mm), 32'd0);
      end
      if (tbl[i].ph == 8'd2) begin
        chk("silence_ticks", 32'(t1 - t0), 32'd96);
        chk("silence_muted", 32'(sil_mute_bad), 32'd0);
      end
    end

    // Restart mid-PLAY: phrase 1 interrupted by phrase 2
    rsp_lat = 0; cen_per = 1;
    got_nibs.delete();
    @(negedge clk);
    phrase = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_nibs.size() < 40 && n < 5000) begin @(negedge clk); n++; end
    chk("restart_play_reached", 32'(got_nibs.size() >= 40), 32'd1);
    chk("play_mute",    32'(mute),    32'd0);
    chk("play_dec_rst", 32'(dec_rst), 32'd0);
    phrase = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_reads.delete();
    got_nibs.delete();
    chk("restart_no_valid",  32'(dec_valid),  32'd0);
    chk("restart_flush",     32'(ctrl_busyn), 32'd1);
    chk("restart_addr_zero", 32'(ctrl_addr),  32'd0);
    @(negedge clk);
    chk("restart_flush_1clk", 32'(ctrl_busyn), 32'd0);
    n = 0;
    while (busyn !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    chk("restart_done", 32'(busyn), 32'd1);
    repeat (2) @(negedge clk);
    model(8'd2);
    cmp_model("restart");

    // Asynchronous reset mid-PLAY
    rsp_lat = 0; cen_per = 2;
    got_nibs.delete();
    @(negedge clk);
    phrase = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_nibs.size() < 20 && n < 5000) begin @(negedge clk); n++; end
    chk("areset_play_reached", 32'(got_nibs.size() >= 20), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("areset_outputs",
        32'({busyn, ctrl_cs, ctrl_busyn, ctrl_addr, dec_valid, dec_nibble, dec_rst, mute}),
        32'({1'b1, 1'b0, 1'b1, 17'd0, 1'b0, 4'd0, 1'b1, 1'b1}));
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Random phrase contents and pacing against the reference
    for (int r = 0; r < 6; r++) begin
      gen_rand();
      rph = 8'($urandom_range(0, 5));
      run_phrase(rph, $urandom_range(0, 3), $urandom_range(1, 5));
      model(rph);
      cmp_model($sformatf("rand%0d_ph%0d", r, rph));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
